// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg : shared types for the single-port memory arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  localparam int WAIT_W = 16;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_t;

  function automatic arb_state_t own_state(input logic idx);
    return idx ? ARB_OWN1 : ARB_OWN0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_port_arbiter_if : requester and memory-side bus of the port arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 12
);
  logic [1:0]             req;
  logic [1:0]             lock;
  logic [1:0]             we;
  logic [1:0][ADDR_W-1:0] addr;
  logic [1:0][WIDTH-1:0]  wdata;
  logic [1:0]             gnt;
  logic [1:0]             rvalid;
  logic [WIDTH-1:0]       rdata;
  logic [ADDR_W-1:0]      mem_addr;
  logic [WIDTH-1:0]       mem_data;
  logic                   mem_wren;
  logic [WIDTH-1:0]       mem_q;
  logic [15:0]            wait_cycles;

  modport slave (
    input  req, lock, we, addr, wdata, mem_q,
    output gnt, rvalid, rdata, mem_addr, mem_data, mem_wren, wait_cycles
  );

  modport master (
    output req, lock, we, addr, wdata, mem_q,
    input  gnt, rvalid, rdata, mem_addr, mem_data, mem_wren, wait_cycles
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_sat_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sat_counter : up-counter with synchronous clear that sticks at all-ones
// Rev 1.0
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             inc_i,
  input  wire logic             clr_i,
  output logic      [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_port_arbiter : two-requester arbiter with locked bursts for one memory port
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int ADDR_W    = 12,
  parameter int MAX_BURST = 16
) (
  input  wire logic         clk,
  input  wire logic         rst,
  mem_port_arbiter_if.slave bus
);

  localparam int                   BEATS_W   = $clog2(MAX_BURST) + 1;
  localparam logic [BEATS_W-1:0]   BEATS_MAX = BEATS_W'(MAX_BURST);

  arb_state_t          state_q, state_d;
  logic                last_q, last_d;
  logic [BEATS_W-1:0]  beats_q, beats_d;
  logic [1:0]          rvalid_q, rvalid_d;
  logic [WIDTH-1:0]    rdata_q, rdata_d;

  logic                owned;
  logic                owner;
  logic                beat;
  logic                other_req;
  logic                cap_hit;
  logic                wait_inc;

  logic [1:0]          gnt;
  logic [ADDR_W-1:0]   mem_addr;
  logic [WIDTH-1:0]    mem_data;
  logic                mem_wren;

  assign owned     = (state_q != ARB_IDLE);
  assign owner     = (state_q == ARB_OWN1);
  assign beat      = owned & bus.req[owner];
  assign other_req = bus.req[~owner];
  assign cap_hit   = (beats_q + BEATS_W'(1)) >= BEATS_MAX;
  assign wait_inc  = (|bus.req) & ~beat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      last_q  <= 1'b1;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      beats_q <= beats_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ARB_IDLE: begin
        if (bus.req[0] && bus.req[1]) begin
          state_d = own_state(~last_q);
        end else if (bus.req[0]) begin
          state_d = ARB_OWN0;
        end else if (bus.req[1]) begin
          state_d = ARB_OWN1;
        end
      end
      ARB_OWN0, ARB_OWN1: begin
        if (!beat) begin
          state_d = other_req ? own_state(~owner) : ARB_IDLE;
        end else if (other_req && (!bus.lock[owner] || cap_hit)) begin
          // Yielding after a beat with the other side waiting flips priority.
          state_d = own_state(~owner);
          last_d  = owner;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    // Saturating at MAX_BURST keeps a long uncontested lock from wrapping.
    if ((state_d != state_q) || (state_d == ARB_IDLE)) begin
      beats_d = '0;
    end else if (beat && (beats_q != BEATS_MAX)) begin
      beats_d = beats_q + BEATS_W'(1);
    end else begin
      beats_d = beats_q;
    end
  end

  always_comb begin
    gnt      = '0;
    mem_addr = '0;
    mem_data = '0;
    mem_wren = 1'b0;
    if (owned) begin
      gnt[owner] = 1'b1;
      mem_addr   = bus.addr[owner];
      mem_data   = bus.wdata[owner];
      mem_wren   = bus.req[owner] & bus.we[owner];
    end
  end

  // The memory runs on the inverted clock, so mem_q is ready by the edge ending the beat.
  always_comb begin
    rvalid_d = bus.req & gnt & ~bus.we;
    rdata_d  = (|rvalid_d) ? bus.mem_q : rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  sat_counter #(
    .WIDTH (WAIT_W)
  ) u_wait_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (wait_inc),
    .clr_i   (1'b0),
    .count_o (bus.wait_cycles)
  );

  assign bus.gnt      = gnt;
  assign bus.mem_addr = mem_addr;
  assign bus.mem_data = mem_data;
  assign bus.mem_wren = mem_wren;
  assign bus.rvalid   = rvalid_q;
  assign bus.rdata    = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter : scoreboard bench for mem_port_arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int WIDTH     = 16;
  localparam int ADDR_W    = 12;
  localparam int MAX_BURST = 16;

  logic clk = 1'b0;
  logic rst;

  mem_port_arbiter_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  mem_port_arbiter #(
    .WIDTH     (WIDTH),
    .ADDR_W    (ADDR_W),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        id;
    logic [15:0] data;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] mem [int];

  function automatic logic [15:0] mem_init(input logic [11:0] a);
    if (a == 12'h010) return 16'h1234;
    return {a, 4'hA};
  endfunction

  // Memory model clocked on the falling edge; read returns pre-write contents.
  always @(negedge clk) begin
    bus.mem_q <= mem.exists(int'(bus.mem_addr)) ? mem[int'(bus.mem_addr)] : mem_init(bus.mem_addr);
    if (bus.mem_wren) mem[int'(bus.mem_addr)] = bus.mem_data;
  end

  // Read-return monitor: every rvalid must match the oldest expected read.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      for (int x = 0; x < 2; x++) begin
        if (bus.rvalid[x]) begin
          n_checks++;
          if (sb_q.size() == 0) begin
            $display("FAIL rvalid_unexpected: requester %0d rvalid with no read pending, rdata=%h", x, bus.rdata);
          end else begin
            e = sb_q.pop_front();
            if ((int'(e.id) != x) || (bus.rdata !== e.data))
              $display("FAIL read_return: got req%0d data=%h, expected req%0d data=%h", x, bus.rdata, e.id, e.data);
            else
              n_pass++;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req   = '0;
    bus.lock  = '0;
    bus.we    = '0;
    bus.addr  = '0;
    bus.wdata = '0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
  endtask

  task automatic check_drained(input string name);
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL %s_drain: %0d reads outstanding, expected 0", name, sb_q.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    n_checks++; if (bus.gnt !== 2'b00)       $display("FAIL reset_gnt: gnt=%b expected=00", bus.gnt); else n_pass++;
    n_checks++; if (bus.rvalid !== 2'b00)    $display("FAIL reset_rvalid: rvalid=%b expected=00", bus.rvalid); else n_pass++;
    n_checks++; if (bus.rdata !== 16'h0)     $display("FAIL reset_rdata: rdata=%h expected=0000", bus.rdata); else n_pass++;
    n_checks++; if (bus.mem_wren !== 1'b0)   $display("FAIL reset_wren: mem_wren=%b expected=0", bus.mem_wren); else n_pass++;
    n_checks++; if (bus.mem_addr !== 12'h0)  $display("FAIL reset_addr: mem_addr=%h expected=000", bus.mem_addr); else n_pass++;
    n_checks++; if (bus.mem_data !== 16'h0)  $display("FAIL reset_data: mem_data=%h expected=0000", bus.mem_data); else n_pass++;
    n_checks++; if (bus.wait_cycles !== 16'h0) $display("FAIL reset_wait: wait_cycles=%0d expected=0", bus.wait_cycles); else n_pass++;
  endtask

  task automatic test_single_read();
    reset_dut();
    bus.req[0]  = 1'b1;
    bus.we[0]   = 1'b0;
    bus.addr[0] = 12'h010;
    #1;
    n_checks++; if (bus.gnt !== 2'b00) $display("FAIL single_arb_cycle: gnt=%b expected=00", bus.gnt); else n_pass++;
    step();
    n_checks++; if (bus.gnt !== 2'b01) $display("FAIL single_gnt: gnt=%b expected=01", bus.gnt); else n_pass++;
    n_checks++; if (bus.mem_addr !== 12'h010) $display("FAIL single_addr: mem_addr=%h expected=010", bus.mem_addr); else n_pass++;
    sb_q.push_back({1'b0, 16'h1234});
    step();
    n_checks++; if (bus.rvalid !== 2'b01) $display("FAIL single_rvalid: rvalid=%b expected=01", bus.rvalid); else n_pass++;
    n_checks++; if (bus.rdata !== 16'h1234) $display("FAIL single_rdata: rdata=%h expected=1234", bus.rdata); else n_pass++;
    bus.req[0] = 1'b0;
    step();
    n_checks++; if (bus.rvalid !== 2'b00) $display("FAIL single_rvalid_pulse: rvalid=%b expected=00", bus.rvalid); else n_pass++;
    n_checks++; if (bus.gnt !== 2'b00) $display("FAIL single_idle: gnt=%b expected=00", bus.gnt); else n_pass++;
    n_checks++; if (bus.wait_cycles !== 16'd1) $display("FAIL single_wait: wait_cycles=%0d expected=1", bus.wait_cycles); else n_pass++;
    step();
    check_drained("single");
  endtask

  task automatic test_tie();
    logic [11:0] a [2];
    logic [1:0]  exp_gnt;
    a[0] = 12'h020;
    a[1] = 12'h021;
    reset_dut();
    bus.addr[0] = a[0];
    bus.addr[1] = a[1];
    bus.req     = 2'b11;
    for (int k = 0; k < 6; k++) begin
      step();
      exp_gnt = (k % 2 == 1) ? 2'b10 : 2'b01;
      n_checks++;
      if (bus.gnt !== exp_gnt) $display("FAIL tie_alternate[%0d]: gnt=%b expected=%b", k, bus.gnt, exp_gnt);
      else n_pass++;
      sb_q.push_back({1'(k % 2), mem_init(a[k % 2])});
    end
    step();
    bus.req = 2'b00;
    step();
    step();
    check_drained("tie");
  endtask

  task automatic test_burst_cap();
    reset_dut();
    bus.lock    = 2'b01;
    bus.addr[0] = 12'h040;
    bus.addr[1] = 12'h0A0;
    bus.req     = 2'b11;
    for (int i = 0; i < 16; i++) begin
      step();
      n_checks++;
      if (bus.gnt !== 2'b01) $display("FAIL burst_owner[%0d]: gnt=%b expected=01", i, bus.gnt);
      else n_pass++;
      bus.addr[0] = 12'h040 + 12'(i);
      sb_q.push_back({1'b0, mem_init(12'h040 + 12'(i))});
    end
    step();
    n_checks++; if (bus.gnt !== 2'b10) $display("FAIL burst_cap_switch: gnt=%b expected=10", bus.gnt); else n_pass++;
    sb_q.push_back({1'b1, mem_init(12'h0A0)});
    step();
    bus.req[1] = 1'b0;
    for (int i = 16; i < 20; i++) begin
      if (i > 16) step();
      n_checks++;
      if (bus.gnt !== 2'b01) $display("FAIL burst_resume[%0d]: gnt=%b expected=01", i, bus.gnt);
      else n_pass++;
      bus.addr[0] = 12'h040 + 12'(i);
      sb_q.push_back({1'b0, mem_init(12'h040 + 12'(i))});
    end
    step();
    bus.req  = 2'b00;
    bus.lock = 2'b00;
    step();
    step();
    n_checks++; if (bus.wait_cycles !== 16'd1) $display("FAIL burst_wait: wait_cycles=%0d expected=1", bus.wait_cycles); else n_pass++;
    check_drained("burst");
  endtask

  task automatic test_parking();
    reset_dut();
    bus.req[1]   = 1'b1;
    bus.we[1]    = 1'b1;
    bus.addr[1]  = 12'h0FF;
    bus.wdata[1] = 16'hBEEF;
    step();
    n_checks++; if (bus.gnt !== 2'b10) $display("FAIL park_wr_gnt: gnt=%b expected=10", bus.gnt); else n_pass++;
    n_checks++; if (bus.mem_wren !== 1'b1) $display("FAIL park_wren: mem_wren=%b expected=1", bus.mem_wren); else n_pass++;
    n_checks++; if (bus.mem_data !== 16'hBEEF) $display("FAIL park_wdata: mem_data=%h expected=beef", bus.mem_data); else n_pass++;
    step();
    bus.we[1] = 1'b0;
    #1;
    n_checks++; if (bus.gnt !== 2'b10) $display("FAIL park_rd_gnt: gnt=%b expected=10", bus.gnt); else n_pass++;
    n_checks++; if (bus.mem_wren !== 1'b0) $display("FAIL park_rd_wren: mem_wren=%b expected=0", bus.mem_wren); else n_pass++;
    sb_q.push_back({1'b1, 16'hBEEF});
    step();
    n_checks++; if (bus.rdata !== 16'hBEEF) $display("FAIL park_rdata: rdata=%h expected=beef", bus.rdata); else n_pass++;
    bus.req[1]  = 1'b0;
    bus.req[0]  = 1'b1;
    bus.we[0]   = 1'b0;
    bus.addr[0] = 12'h0FF;
    step();
    n_checks++; if (bus.gnt !== 2'b01) $display("FAIL drop_switch_gnt: gnt=%b expected=01", bus.gnt); else n_pass++;
    sb_q.push_back({1'b0, 16'hBEEF});
    step();
    bus.req = 2'b00;
    n_checks++; if (bus.wait_cycles !== 16'd2) $display("FAIL park_wait: wait_cycles=%0d expected=2", bus.wait_cycles); else n_pass++;
    step();
    step();
    check_drained("park");
  endtask

  task automatic test_reset_mid_burst();
    reset_dut();
    bus.addr[0] = 12'h020;
    bus.addr[1] = 12'h0A0;
    bus.req     = 2'b11;
    step();
    n_checks++; if (bus.gnt !== 2'b01) $display("FAIL mid_first_gnt: gnt=%b expected=01", bus.gnt); else n_pass++;
    sb_q.push_back({1'b0, mem_init(12'h020)});
    step();
    bus.req[0]  = 1'b0;
    bus.lock[1] = 1'b1;
    step();
    bus.we[1]    = 1'b1;
    bus.addr[1]  = 12'h0C0;
    bus.wdata[1] = 16'h5A5A;
    #1;
    n_checks++; if (bus.mem_wren !== 1'b1) $display("FAIL mid_wren_before: mem_wren=%b expected=1", bus.mem_wren); else n_pass++;
    #1;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.gnt !== 2'b00) $display("FAIL mid_rst_gnt: gnt=%b expected=00", bus.gnt); else n_pass++;
    n_checks++; if (bus.mem_wren !== 1'b0) $display("FAIL mid_rst_wren: mem_wren=%b expected=0", bus.mem_wren); else n_pass++;
    n_checks++; if (bus.rvalid !== 2'b00) $display("FAIL mid_rst_rvalid: rvalid=%b expected=00", bus.rvalid); else n_pass++;
    n_checks++; if (bus.rdata !== 16'h0) $display("FAIL mid_rst_rdata: rdata=%h expected=0000", bus.rdata); else n_pass++;
    bus.req     = 2'b11;
    bus.lock    = 2'b00;
    bus.we      = 2'b00;
    bus.addr[1] = 12'h0A0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    step();
    n_checks++; if (bus.gnt !== 2'b01) $display("FAIL mid_tie_after_reset: gnt=%b expected=01", bus.gnt); else n_pass++;
    sb_q.push_back({1'b0, mem_init(12'h020)});
    step();
    bus.req = 2'b00;
    step();
    step();
    check_drained("mid");
  endtask

  task automatic test_wait_saturation();
    logic [15:0] exp_wait;
    reset_dut();
    for (int n = 1; n <= 65600; n++) begin
      bus.req = n[0] ? 2'b01 : 2'b10;
      step();
      if ((n == 100) || (n == 65534) || (n == 65535) || (n == 65600)) begin
        exp_wait = (n > 65535) ? 16'hFFFF : 16'(n);
        n_checks++;
        if (bus.wait_cycles !== exp_wait) $display("FAIL wait_count[%0d]: wait_cycles=%0d expected=%0d", n, bus.wait_cycles, exp_wait);
        else n_pass++;
      end
      if (n == 100) begin
        n_checks++;
        if (bus.gnt !== 2'b10) $display("FAIL wait_pingpong_gnt: gnt=%b expected=10", bus.gnt);
        else n_pass++;
      end
    end
    bus.req = 2'b00;
    step();
    step();
    check_drained("sat");
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_single_read();
    test_tie();
    test_burst_cap();
    test_parking();
    test_reset_mid_burst();
    test_wait_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
